// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address controller for the microprogrammed control unit.
// Holds the micro-PC that addresses the control store and picks the next one each
// cycle from increment, jump, conditional branch, call/return, IB/SB dispatch or fetch.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high
//   stall_i      memory wait; freezes all sequencer state
//   seq_op_i     next-address op from the current microword
//   br_addr_i    branch/jump/call target from the current microword
//   cond_sel_i   00 Z, 01 C, 10 !Z, 11 always
//   z_flag_i     ALU zero flag
//   c_flag_i     ALU carry flag
//   ib_i         decoder initial dispatch address
//   sb_i         decoder secondary dispatch address
//   upc_o        registered micro-PC (control-store address)
//   depth_o      return-stack occupancy
//   ill_op_o     one-cycle pulse after an illegal instruction was dispatched
//   stack_err_o  sticky overflow/underflow flag, cleared only by reset
module micro_sequencer #(
  parameter int unsigned          AW          = 5,
  parameter int unsigned          STACK_DEPTH = 2,
  parameter logic [AW-1:0]        FETCH_ADDR  = 5'b00000,
  parameter logic [AW-1:0]        ILL_CODE    = 5'b11111,
  parameter logic [AW-1:0]        TRAP_ADDR   = 5'b11110
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic [2:0]    seq_op_i,
  input  logic [AW-1:0] br_addr_i,
  input  logic [1:0]    cond_sel_i,
  input  logic          z_flag_i,
  input  logic          c_flag_i,
  input  logic [AW-1:0] ib_i,
  input  logic [AW-1:0] sb_i,
  output logic [AW-1:0] upc_o,
  output logic [2:0]    depth_o,
  output logic          ill_op_o,
  output logic          stack_err_o
);

  typedef enum logic [2:0] {
    OpNext   = 3'b000,
    OpJump   = 3'b001,
    OpDispIb = 3'b010,
    OpDispSb = 3'b011,
    OpBrCond = 3'b100,
    OpCall   = 3'b101,
    OpRet    = 3'b110,
    OpFetch  = 3'b111
  } seq_op_e;

  logic [AW-1:0] upc_q, upc_d;
  logic [2:0]    depth_q, depth_d;
  logic          ill_q, ill_d;
  logic          err_q, err_d;
  logic [AW-1:0] stack_q [STACK_DEPTH];
  logic [AW-1:0] stack_d [STACK_DEPTH];

  logic [AW-1:0] inc;
  logic          cond;
  logic [AW-1:0] top;
  logic          full;

  assign inc  = upc_q + 1'b1;
  assign full = (depth_q == 3'(STACK_DEPTH));

  always_comb begin
    unique case (cond_sel_i)
      2'b00:   cond = z_flag_i;
      2'b01:   cond = c_flag_i;
      2'b10:   cond = ~z_flag_i;
      default: cond = 1'b1;
    endcase
  end

  // Top of stack is the entry just below depth_q.
  always_comb begin
    top = FETCH_ADDR;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (3'(i + 1) == depth_q) top = stack_q[i];
    end
  end

  always_comb begin
    upc_d   = upc_q;
    depth_d = depth_q;
    ill_d   = 1'b0;
    err_d   = err_q;
    stack_d = stack_q;
    if (!stall_i) begin
      unique case (seq_op_e'(seq_op_i))
        OpNext:   upc_d = inc;
        OpJump:   upc_d = br_addr_i;
        OpDispIb: begin
          if (ib_i == ILL_CODE) begin
            upc_d = TRAP_ADDR;
            ill_d = 1'b1;
          end else begin
            upc_d = ib_i;
          end
        end
        OpDispSb: upc_d = sb_i;
        OpBrCond: upc_d = cond ? br_addr_i : inc;
        OpCall: begin
          upc_d = br_addr_i;
          if (full) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
              if (3'(i) == depth_q) stack_d[i] = inc;
            end
            depth_d = depth_q + 3'd1;
          end
        end
        OpRet: begin
          if (depth_q != 3'd0) begin
            upc_d   = top;
            depth_d = depth_q - 3'd1;
          end else begin
            upc_d = FETCH_ADDR;
            err_d = 1'b1;
          end
        end
        OpFetch: begin
          upc_d   = FETCH_ADDR;
          depth_d = 3'd0;
        end
        default: upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upc_q   <= FETCH_ADDR;
      depth_q <= 3'd0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      upc_q   <= upc_d;
      depth_q <= depth_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign upc_o       = upc_q;
  assign depth_o     = depth_q;
  assign ill_op_o    = ill_q;
  assign stack_err_o = err_q;

endmodule
